// File: rtl/aexm_dmem_resp.sv
// Data-bus responder: services core word/half/byte requests against a word-wide
// single-port memory, using read-modify-write for partial stores.
module aexm_dmem_resp #(
  parameter int DW   = 32,
  parameter int TOUT = 255
) (
  input  logic          gclk,
  input  logic          grst,
  input  logic          dwb_stb,
  input  logic          dwb_wre,
  input  logic [DW-3:0] dwb_adr,
  input  logic [3:0]    dwb_sel,
  input  logic [31:0]   dwb_dto,
  output logic          dwb_ack,
  output logic [31:0]   dwb_dti,
  output logic          dwb_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW-3:0] mem_adr,
  output logic [31:0]   mem_wdat,
  input  logic          mem_gnt,
  input  logic [31:0]   mem_rdat,
  input  logic          mem_rvalid
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [7:0] TOUT_LAST = 8'(TOUT - 1);

  state_t        state_r, state_nxt;
  logic [7:0]    cnt_r, cnt_nxt;
  logic          wre_r, wre_nxt;
  logic [3:0]    sel_r, sel_nxt;
  logic [31:0]   dto_r, dto_nxt;
  logic          ack_r, ack_nxt;
  logic          err_r, err_nxt;
  logic [31:0]   dti_r, dti_nxt;
  logic          req_r, req_nxt;
  logic          we_r, we_nxt;
  logic [DW-3:0] adr_r, adr_nxt;
  logic [31:0]   wdat_r, wdat_nxt;

  logic accept_s, bad_sel_s, tmo_s, tmo_hit_s, load_hit_s, merge_s;

  function automatic logic sel_legal(input logic [3:0] sel);
    case (sel)
      4'h8, 4'h4, 4'h2, 4'h1, 4'hC, 4'h3, 4'hF: sel_legal = 1'b1;
      default:                                 sel_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] lane_extract(input logic [31:0] w, input logic [3:0] sel);
    case (sel)
      4'h8:    lane_extract = {24'h000000, w[31:24]};
      4'h4:    lane_extract = {24'h000000, w[23:16]};
      4'h2:    lane_extract = {24'h000000, w[15:8]};
      4'h1:    lane_extract = {24'h000000, w[7:0]};
      4'hC:    lane_extract = {16'h0000, w[31:16]};
      4'h3:    lane_extract = {16'h0000, w[15:0]};
      4'hF:    lane_extract = w;
      default: lane_extract = 32'h00000000;
    endcase
  endfunction

  // Store data is replicated across lanes, then only the selected lanes replace the old word.
  function automatic logic [31:0] lane_merge(input logic [31:0] w, input logic [31:0] d,
                                             input logic [3:0] sel);
    logic [31:0] mask;
    logic [31:0] rep;
    mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    case (sel)
      4'hC, 4'h3: rep = {2{d[15:0]}};
      4'hF:       rep = d;
      default:    rep = {4{d[7:0]}};
    endcase
    lane_merge = (w & ~mask) | (rep & mask);
  endfunction

  assign accept_s   = (state_r == IDLE) && dwb_stb;
  assign bad_sel_s  = accept_s && !sel_legal(dwb_sel) && (dwb_sel != 4'h0);
  assign tmo_s      = (cnt_r == TOUT_LAST);
  // A handshake in the same cycle as the limit takes precedence over the abort.
  assign tmo_hit_s  = tmo_s && (((state_r == RD_REQ) && !mem_gnt) ||
                                ((state_r == RD_WAIT) && !mem_rvalid) ||
                                ((state_r == WR_REQ) && !mem_gnt));
  assign load_hit_s = (state_r == RD_WAIT) && mem_rvalid && !wre_r;
  assign merge_s    = (state_r == RD_WAIT) && mem_rvalid && wre_r;

  // State register.
  always_ff @(posedge gclk) begin
    if (grst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (!dwb_stb) begin
          state_nxt = IDLE;
        end else if (!sel_legal(dwb_sel)) begin
          state_nxt = DONE;
        end else if (dwb_wre && (dwb_sel == 4'hF)) begin
          state_nxt = WR_REQ;
        end else begin
          state_nxt = RD_REQ;
        end
      end
      RD_REQ: begin
        if (mem_gnt) begin
          state_nxt = RD_WAIT;
        end else if (tmo_s) begin
          state_nxt = DONE;
        end else begin
          state_nxt = RD_REQ;
        end
      end
      RD_WAIT: begin
        if (mem_rvalid) begin
          state_nxt = wre_r ? WR_REQ : DONE;
        end else if (tmo_s) begin
          state_nxt = DONE;
        end else begin
          state_nxt = RD_WAIT;
        end
      end
      WR_REQ: begin
        if (mem_gnt || tmo_s) begin
          state_nxt = DONE;
        end else begin
          state_nxt = WR_REQ;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs, counter and request latch.
  always_comb begin
    cnt_nxt  = cnt_r;
    wre_nxt  = wre_r;
    sel_nxt  = sel_r;
    dto_nxt  = dto_r;
    ack_nxt  = 1'b0;
    err_nxt  = 1'b0;
    dti_nxt  = dti_r;
    req_nxt  = 1'b0;
    we_nxt   = 1'b0;
    adr_nxt  = adr_r;
    wdat_nxt = wdat_r;

    if ((state_nxt == RD_REQ) || (state_nxt == RD_WAIT) || (state_nxt == WR_REQ)) begin
      req_nxt = (state_nxt != RD_WAIT);
      we_nxt  = (state_nxt == WR_REQ);
      if (state_nxt != state_r) begin
        cnt_nxt = 8'd0;
      end else begin
        cnt_nxt = cnt_r + 8'd1;
      end
    end else begin
      cnt_nxt = cnt_r;
    end

    if (accept_s) begin
      wre_nxt = dwb_wre;
      sel_nxt = dwb_sel;
      dto_nxt = dwb_dto;
      adr_nxt = dwb_adr;
      if (dwb_wre && (dwb_sel == 4'hF)) begin
        wdat_nxt = dwb_dto;
      end else begin
        wdat_nxt = wdat_r;
      end
    end else if (merge_s) begin
      wdat_nxt = lane_merge(mem_rdat, dto_r, sel_r);
    end else begin
      wdat_nxt = wdat_r;
    end

    if (state_nxt == DONE) begin
      ack_nxt = 1'b1;
      err_nxt = bad_sel_s || tmo_hit_s;
      dti_nxt = load_hit_s ? lane_extract(mem_rdat, sel_r) : 32'h00000000;
    end else begin
      ack_nxt = 1'b0;
      err_nxt = 1'b0;
    end
  end

  // Output, counter and request-latch registers.
  always_ff @(posedge gclk) begin
    if (grst) begin
      cnt_r  <= 8'd0;
      wre_r  <= 1'b0;
      sel_r  <= 4'h0;
      dto_r  <= 32'h00000000;
      ack_r  <= 1'b0;
      err_r  <= 1'b0;
      dti_r  <= 32'h00000000;
      req_r  <= 1'b0;
      we_r   <= 1'b0;
      adr_r  <= '0;
      wdat_r <= 32'h00000000;
    end else begin
      cnt_r  <= cnt_nxt;
      wre_r  <= wre_nxt;
      sel_r  <= sel_nxt;
      dto_r  <= dto_nxt;
      ack_r  <= ack_nxt;
      err_r  <= err_nxt;
      dti_r  <= dti_nxt;
      req_r  <= req_nxt;
      we_r   <= we_nxt;
      adr_r  <= adr_nxt;
      wdat_r <= wdat_nxt;
    end
  end

  assign dwb_ack  = ack_r;
  assign dwb_err  = err_r;
  assign dwb_dti  = dti_r;
  assign mem_req  = req_r;
  assign mem_we   = we_r;
  assign mem_adr  = adr_r;
  assign mem_wdat = wdat_r;

endmodule

// File: tb/tb_aexm_dmem_resp.sv
// Bench for aexm_dmem_resp: acts as core and memory, predicting ack timing, data,
// error and memory traffic from a lane-mask model of each request.
module tb_aexm_dmem_resp;
  localparam int TOUT = 4;

  logic        gclk = 1'b0;
  logic        grst, dwb_stb, dwb_wre, mem_gnt, mem_rvalid;
  logic [29:0] dwb_adr;
  logic [3:0]  dwb_sel;
  logic [31:0] dwb_dto, mem_rdat;
  logic        dwb_ack, dwb_err, mem_req, mem_we;
  logic [31:0] dwb_dti, mem_wdat;
  logic [29:0] mem_adr;

  logic [31:0] mem [0:15];
  int n_cmp = 0;
  int n_mis = 0;

  aexm_dmem_resp #(.DW(32), .TOUT(TOUT)) dut (
    .gclk(gclk), .grst(grst),
    .dwb_stb(dwb_stb), .dwb_wre(dwb_wre), .dwb_adr(dwb_adr), .dwb_sel(dwb_sel),
    .dwb_dto(dwb_dto), .dwb_ack(dwb_ack), .dwb_dti(dwb_dti), .dwb_err(dwb_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdat(mem_wdat),
    .mem_gnt(mem_gnt), .mem_rdat(mem_rdat), .mem_rvalid(mem_rvalid)
  );

  always #5 gclk = ~gclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One core transaction. Called at a negedge; gd1/gd2 are grant delays (cycles of
  // mem_req before mem_gnt) for the read and write phases, rd is the rvalid delay.
  task automatic txn(input logic wre, input logic [29:0] adr, input logic [3:0] sel,
                     input logic [31:0] dto, input int gd1, input int rd, input int gd2);
    logic [31:0] word, mask, exp_dti, exp_wdat;
    logic        exp_err, legal, ack_found;
    int shift, exp_ack, exp_rds, exp_wrs, exp_req;
    int ack_at, req_run, rv_wait, rds, wrs, reqs;
    word = mem[adr[3:0]];
    mask = 32'h0;
    shift = -1;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) begin
        mask = mask | (32'hFF << (8 * i));
        if (shift < 0) shift = 8 * i;
      end
    end
    legal = sel inside {4'h8, 4'h4, 4'h2, 4'h1, 4'hC, 4'h3, 4'hF};
    exp_dti = 32'h0; exp_wdat = 32'h0; exp_err = 1'b0;
    exp_rds = 0; exp_wrs = 0; exp_req = 0;
    if (!legal) begin
      exp_err = (sel != 4'h0);
      exp_ack = 1;
    end else if (wre && sel == 4'hF) begin
      exp_wdat = dto;
      exp_req  = (gd2 >= TOUT) ? TOUT : gd2 + 1;
      if (gd2 >= TOUT) begin exp_err = 1'b1; exp_ack = TOUT + 1; end
      else begin exp_wrs = 1; exp_ack = 2 + gd2; end
    end else begin
      exp_req = (gd1 >= TOUT) ? TOUT : gd1 + 1;
      if (gd1 >= TOUT) begin
        exp_err = 1'b1; exp_ack = TOUT + 1;
      end else begin
        exp_rds = 1;
        if (rd >= TOUT) begin
          exp_err = 1'b1; exp_ack = 2 + gd1 + TOUT;
        end else if (!wre) begin
          exp_dti = (word & mask) >> shift;
          exp_ack = 3 + gd1 + rd;
        end else begin
          exp_wdat = (word & ~mask) | ((dto << shift) & mask);
          exp_req += (gd2 >= TOUT) ? TOUT : gd2 + 1;
          if (gd2 >= TOUT) begin exp_err = 1'b1; exp_ack = 3 + gd1 + rd + TOUT; end
          else begin exp_wrs = 1; exp_ack = 4 + gd1 + rd + gd2; end
        end
      end
    end

    dwb_stb = 1'b1; dwb_wre = wre; dwb_adr = adr; dwb_sel = sel; dwb_dto = dto;
    ack_at = -1; ack_found = 1'b0; req_run = 0; rv_wait = -1; rds = 0; wrs = 0; reqs = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge gclk);
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdat = $urandom;
      // Request fields are sampled only at accept, so scramble them afterwards.
      dwb_wre = 1'($urandom); dwb_adr = 30'($urandom); dwb_sel = 4'($urandom); dwb_dto = $urandom;
      if (ack_at >= 0) begin
        chk("ack_width", {31'h0, dwb_ack}, 32'h0);
        chk("err_after", {31'h0, dwb_err}, 32'h0);
        chk("req_after", {31'h0, mem_req}, 32'h0);
        chk("dti_hold", dwb_dti, exp_dti);
        dwb_stb = 1'b0;
        break;
      end
      if (dwb_ack === 1'b1) begin
        ack_at = c; ack_found = 1'b1;
        chk("ack_cycle", c, exp_ack);
        chk("err", {31'h0, dwb_err}, {31'h0, exp_err});
        chk("dti", dwb_dti, exp_dti);
        chk("req_at_ack", {31'h0, mem_req}, 32'h0);
        chk("req_cycles", reqs, exp_req);
        chk("reads", rds, exp_rds);
        chk("writes", wrs, exp_wrs);
        continue;
      end
      if (rv_wait >= 0) begin
        if (rv_wait == rd) begin
          mem_rvalid = 1'b1; mem_rdat = mem[adr[3:0]]; rv_wait = -1;
        end else begin
          rv_wait++;
        end
      end
      if (mem_req === 1'b1) begin
        reqs++;
        if (req_run == (mem_we ? gd2 : gd1)) begin
          mem_gnt = 1'b1;
          if (mem_we) begin
            wrs++;
            chk("wr_adr", {2'b0, mem_adr}, {2'b0, adr});
            chk("wr_data", mem_wdat, exp_wdat);
            mem[adr[3:0]] = mem_wdat;
          end else begin
            rds++;
            chk("rd_adr", {2'b0, mem_adr}, {2'b0, adr});
            rv_wait = 0;
            mem_rvalid = 1'($urandom);  // never the answer in the granting cycle
          end
        end
        req_run++;
      end else begin
        req_run = 0;
      end
    end
    chk("ack_seen", {31'h0, ack_found}, 32'h1);
    if (!ack_found) begin
      dwb_stb = 1'b0; grst = 1'b1;
      @(negedge gclk);
      grst = 1'b0;
    end
  endtask

  initial begin
    logic [3:0] legal_sels [0:6];
    logic [3:0] s;
    legal_sels = '{4'h8, 4'h4, 4'h2, 4'h1, 4'hC, 4'h3, 4'hF};
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    grst = 1'b1; dwb_stb = 1'b0; dwb_wre = 1'b0; dwb_adr = 30'h0; dwb_sel = 4'h0;
    dwb_dto = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdat = 32'h0;
    repeat (3) @(negedge gclk);
    chk("rst_ctrl", {28'h0, dwb_ack, dwb_err, mem_req, mem_we}, 32'h0);
    chk("rst_dti", dwb_dti, 32'h0);
    chk("rst_adr", {2'b0, mem_adr}, 32'h0);
    chk("rst_wdat", mem_wdat, 32'h0);
    grst = 1'b0;
    @(negedge gclk);

    // Directed steps.
    mem[0] = 32'hAABBCCDD;
    txn(1'b0, 30'h10, 4'h4, 32'h0, 0, 1, 0);
    txn(1'b1, 30'h10, 4'h1, 32'h12345677, 0, 0, 0);
    chk("rmw_word", mem[0], 32'hAABBCC77);
    txn(1'b0, 30'h10, 4'hC, 32'h0, 0, 0, 0);
    txn(1'b1, 30'h21, 4'hF, 32'hDEADBEEF, 0, 0, 0);
    txn(1'b0, 30'h21, 4'h5, 32'h0, 0, 0, 0);
    txn(1'b0, 30'h21, 4'h0, 32'h0, 0, 0, 0);
    txn(1'b0, 30'h22, 4'h2, 32'h0, 99, 0, 0);
    txn(1'b1, 30'h23, 4'h8, 32'h5A, 0, 99, 0);
    txn(1'b1, 30'h24, 4'hF, 32'h1, 0, 0, 99);
    txn(1'b1, 30'h25, 4'h3, 32'hBEEF, TOUT - 1, TOUT - 1, TOUT - 1);
    txn(1'b0, 30'h25, 4'hF, 32'h0, TOUT - 1, TOUT - 1, 0);

    // Reset while waiting for read data, then a late rvalid in IDLE.
    mem[2] = 32'h11223344;
    txn(1'b0, 30'h2, 4'hF, 32'h0, 0, 0, 0);
    dwb_stb = 1'b1; dwb_wre = 1'b0; dwb_adr = 30'h2; dwb_sel = 4'hF;
    @(negedge gclk);
    mem_gnt = 1'b1;
    @(negedge gclk);
    mem_gnt = 1'b0; dwb_stb = 1'b0; grst = 1'b1;
    @(negedge gclk);
    grst = 1'b0; mem_rvalid = 1'b1; mem_rdat = 32'hCAFEF00D;
    chk("rst_mid_ctrl", {28'h0, dwb_ack, dwb_err, mem_req, mem_we}, 32'h0);
    chk("rst_mid_dti", dwb_dti, 32'h0);
    chk("rst_mid_adr", {2'b0, mem_adr}, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge gclk);
      mem_rvalid = 1'b0;
      chk("rst_late_rv", {28'h0, dwb_ack, dwb_err, mem_req, mem_we}, 32'h0);
      chk("rst_late_dti", dwb_dti, 32'h0);
    end
    txn(1'b0, 30'h2, 4'h8, 32'h0, 1, 0, 0);

    // Randomized requests with varied handshake delays, some beyond the limit.
    for (int n = 0; n < 80; n++) begin
      s = legal_sels[$urandom_range(0, 6)];
      if ($urandom_range(0, 7) == 0) s = 4'($urandom);
      txn(1'($urandom), 30'($urandom), s, $urandom,
          $urandom_range(0, TOUT + 1), $urandom_range(0, TOUT + 1), $urandom_range(0, TOUT + 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
